multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARMv4 control unit: Moore sequencer for the shared datapath,
// NZCV flag register, condition check and gated architectural enables.
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUControl
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
   } state_e;

   state_e      state_q, state_d, out_state;
   logic [3:0]  flags_q, flags_d;

   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  cond;
   logic [3:0]  rd;

   logic        next_pc, branch, reg_w, mem_w, ir_write, alu_op;
   logic        cond_ex, no_write, cv_op;

   assign op    = Instr[27:26];
   assign funct = Instr[25:20];
   assign cond  = Instr[31:28];
   assign rd    = Instr[15:12];

   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};

   // CMP is recognised from the instruction register itself, so the
   // suppression still holds in ALUWB where ALUOp is no longer asserted.
   assign no_write = (op == 2'b00) && (funct[4:1] == 4'b1010);
   assign cv_op    = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010) ||
                     (funct[4:1] == 4'b1010);

   // State and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q <= S_FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   // Next-state sequencing.
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // While reset is held the selects show FETCH values; enables are gated below.
   assign out_state = reset ? S_FETCH : state_q;

   // Moore outputs per state.
   always_comb begin
      next_pc   = 1'b0;
      branch    = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      ir_write  = 1'b0;
      alu_op    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (out_state)
         S_FETCH: begin
            ir_write = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
            ResultSrc = 2'b10; next_pc = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         S_MEMADR:   ALUSrcB = 2'b01;
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01; reg_w = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1; mem_w = 1'b1;
         end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = 2'b01; alu_op = 1'b1;
         end
         S_ALUWB:    reg_w = 1'b1;
         S_BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU operation decode.
   always_comb begin
      ALUControl = 2'b00;
      if (alu_op) begin
         case (funct[4:1])
            4'b0010: ALUControl = 2'b01;
            4'b0000: ALUControl = 2'b10;
            4'b1100: ALUControl = 2'b11;
            4'b1010: ALUControl = 2'b01;
            default: ALUControl = 2'b00;
         endcase
      end
   end

   // Condition-code check against the stored flags {N,Z,C,V}.
   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = flags_q;
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Flag update at the end of EXECUTEx; logical ops keep C and V.
   always_comb begin
      flags_d = flags_q;
      if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) && funct[0] && cond_ex) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (cv_op) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   // Architectural enables, gated by the condition check and by reset.
   always_comb begin
      PCWrite  = ~reset & (next_pc | (cond_ex & (branch | (reg_w & (rd == 4'd15)))));
      RegWrite = ~reset & reg_w & cond_ex & ~no_write;
      MemWrite = ~reset & mem_w & cond_ex;
      IRWrite  = ~reset & ir_write;
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for multicycle_controller: directed instruction
// sequences push expected per-cycle outputs; a negedge monitor compares.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .RegSrc(RegSrc), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   typedef enum int {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB,
      T_MEMWRITE, T_EXECUTER, T_EXECUTEI, T_ALUWB, T_BRANCH
   } tst_e;

   // {PCW,MemW,RegW,IRW, AdrSrc,ALUSrcA,ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl}
   logic [15:0] act_vec;
   assign act_vec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                     ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

   logic [15:0] exp_q[$];
   logic [15:0] mask_q[$];
   string       name_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   // Expected vector and care-mask for one cycle; fields the state leaves
   // unspecified are masked out.
   function automatic void build(input tst_e st, input logic [31:0] ins,
                                 input logic pcw, input logic memw, input logic regw,
                                 input logic irw, input logic [1:0] alu,
                                 output logic [15:0] v, output logic [15:0] m);
      v = '0;
      m = 16'hF03C;
      v[15] = pcw; v[14] = memw; v[13] = regw; v[12] = irw;
      v[5:4] = ins[27:26];
      v[3] = (ins[27:26] == 2'b01);
      v[2] = (ins[27:26] == 2'b10);
      case (st)
         T_FETCH:    begin v[10] = 1'b1; v[9:8] = 2'b10; v[7:6] = 2'b10; m |= 16'h0FC3; end
         T_DECODE:   begin v[10] = 1'b1; v[9:8] = 2'b10; v[7:6] = 2'b10; m |= 16'h07C3; end
         T_MEMADR:   begin v[9:8] = 2'b01; m |= 16'h0703; end
         T_MEMREAD:  begin v[11] = 1'b1; m |= 16'h08C0; end
         T_MEMWB:    begin v[7:6] = 2'b01; m |= 16'h00C0; end
         T_MEMWRITE: begin v[11] = 1'b1; m |= 16'h08C0; end
         T_EXECUTER: begin v[1:0] = alu; m |= 16'h0703; end
         T_EXECUTEI: begin v[9:8] = 2'b01; v[1:0] = alu; m |= 16'h0703; end
         T_ALUWB:    begin m |= 16'h00C0; end
         T_BRANCH:   begin v[9:8] = 2'b01; v[7:6] = 2'b10; m |= 16'h07C3; end
         default: ;
      endcase
   endfunction

   task automatic push(input string nm, input logic [15:0] v, input logic [15:0] m);
      exp_q.push_back(v);
      mask_q.push_back(m);
      name_q.push_back(nm);
   endtask

   // One normal cycle: drive inputs, queue the expectation, advance.
   task automatic step(input string nm, input tst_e st, input logic [31:0] ins,
                       input logic [3:0] fl, input logic pcw, input logic memw,
                       input logic regw, input logic [1:0] alu);
      logic [15:0] v, m;
      reset = 1'b0; Instr = ins; ALUFlags = fl;
      build(st, ins, pcw, memw, regw, st == T_FETCH, alu, v, m);
      push($sformatf("%s.%s", nm, st.name()), v, m);
      @(posedge clk); #1;
   endtask

   // One cycle with reset held: FETCH selects, all enables low.
   task automatic rstep(input string nm, input logic [31:0] ins);
      logic [15:0] v, m;
      reset = 1'b1; Instr = ins; ALUFlags = 4'b1111;
      build(T_FETCH, ins, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, v, m);
      push($sformatf("%s.RESET", nm), v, m);
      @(posedge clk); #1;
   endtask

   task automatic dp(input string nm, input logic [31:0] ins, input logic imm,
                     input logic [3:0] fl, input logic [1:0] alu,
                     input logic pcw_wb, input logic regw_wb);
      step(nm, T_FETCH,  ins, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step(nm, T_DECODE, ins, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step(nm, imm ? T_EXECUTEI : T_EXECUTER, ins, fl, 1'b0, 1'b0, 1'b0, alu);
      step(nm, T_ALUWB,  ins, 4'b0000, pcw_wb, 1'b0, regw_wb, 2'b00);
   endtask

   task automatic br(input string nm, input logic [31:0] ins, input logic taken);
      step(nm, T_FETCH,  ins, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step(nm, T_DECODE, ins, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step(nm, T_BRANCH, ins, 4'b0000, taken, 1'b0, 1'b0, 2'b00);
   endtask

   // Scoreboard monitor: compares once per cycle, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [15:0] e, m;
         string nm;
         e = exp_q.pop_front();
         m = mask_q.pop_front();
         nm = name_q.pop_front();
         n_cmp++;
         if ((act_vec & m) !== (e & m)) begin
            n_bad++;
            $display("FAIL %s: got %04h required %04h (care mask %04h)", nm, act_vec & m, e & m, m);
         end
      end
   end

   initial begin
      reset = 1'b1; Instr = 32'h0; ALUFlags = 4'b0000;
      @(posedge clk); #1;
      rstep("por", 32'hE2802005);
      rstep("por", 32'hE2802005);

      // ADD R2,R0,#5 without S: ALUFlags ignored, flags stay 0000
      dp("add_r2", 32'hE2802005, 1'b1, 4'b1111, 2'b00, 1'b0, 1'b1);
      br("beq_z0", 32'h0A000000, 1'b0);
      br("bne_z0", 32'h1A000000, 1'b1);
      // ADDEQ with Z=0: full path, nothing written
      dp("addeq_fail", 32'h02802005, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);

      // LDR R2,[R0,#96] and STR R7,[R3,#84]
      step("ldr", T_FETCH,   32'hE5902060, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step("ldr", T_DECODE,  32'hE5902060, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step("ldr", T_MEMADR,  32'hE5902060, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step("ldr", T_MEMREAD, 32'hE5902060, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step("ldr", T_MEMWB,   32'hE5902060, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00);
      step("str", T_FETCH,    32'hE5837054, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step("str", T_DECODE,   32'hE5837054, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step("str", T_MEMADR,   32'hE5837054, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step("str", T_MEMWRITE, 32'hE5837054, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);

      // SUBS R8,R7,R2 with ALUFlags 0110 -> flags 0110
      dp("subs", 32'hE0578002, 1'b0, 4'b0110, 2'b01, 1'b0, 1'b1);
      br("beq_z1", 32'h0A000000, 1'b1);
      br("bne_z1", 32'h1A000000, 1'b0);
      // SUBSNE with Z=1 fails: no write, flags kept at 0110
      dp("subsne_fail", 32'h10578002, 1'b0, 4'b0000, 2'b01, 1'b0, 1'b0);
      br("beq_kept", 32'h0A000000, 1'b1);

      // CMP R3,#0 with ALUFlags 1000 -> flags 1000, no register write
      dp("cmp", 32'hE3530000, 1'b1, 4'b1000, 2'b01, 1'b0, 1'b0);
      br("bmi_cmp", 32'h4A000000, 1'b1);
      br("beq_cmp", 32'h0A000000, 1'b0);

      // SUBS -> 0011, ANDS with 0111 -> 0111
      dp("subs_0011", 32'hE0578002, 1'b0, 4'b0011, 2'b01, 1'b0, 1'b1);
      dp("ands", 32'hE0121003, 1'b0, 4'b0111, 2'b10, 1'b0, 1'b1);
      br("beq_ands", 32'h0A000000, 1'b1);
      br("bcs_ands", 32'h2A000000, 1'b1);
      br("bvs_ands", 32'h6A000000, 1'b1);
      br("bmi_ands", 32'h4A000000, 1'b0);
      // ORRS with 1000 from 0111 -> 1011 (C,V preserved)
      dp("orrs", 32'hE1921003, 1'b0, 4'b1000, 2'b11, 1'b0, 1'b1);
      br("bmi_orrs", 32'h4A000000, 1'b1);
      br("bcs_orrs", 32'h2A000000, 1'b1);
      br("bvs_orrs", 32'h6A000000, 1'b1);
      br("bge_orrs", 32'hAA000000, 1'b1);
      br("beq_orrs", 32'h0A000000, 1'b0);

      // Undefined Op 11: FETCH, DECODE, then straight back to FETCH
      step("undef", T_FETCH,  32'hEC000000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step("undef", T_DECODE, 32'hEC000000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      // ADD R15,R0,#5 (AL): PC written in FETCH and ALUWB
      dp("add_pc", 32'hE280F005, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b1);

      // Reset during LDR MEMREAD
      step("ldr_abort", T_FETCH,  32'hE5902060, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step("ldr_abort", T_DECODE, 32'hE5902060, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step("ldr_abort", T_MEMADR, 32'hE5902060, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      rstep("ldr_abort", 32'hE5902060);
      rstep("ldr_abort", 32'hE5902060);
      dp("add_after_rst", 32'hE2802005, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b1);
      // flags cleared by that reset: BEQ not taken, BNE taken
      br("beq_rst", 32'h0A000000, 1'b0);
      br("bne_rst", 32'h1A000000, 1'b1);

      // Reset in place of STR MEMWRITE: MemWrite never pulses
      step("str_abort", T_FETCH,  32'hE5837054, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step("str_abort", T_DECODE, 32'hE5837054, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      step("str_abort", T_MEMADR, 32'hE5837054, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
      rstep("str_abort", 32'hE5837054);
      step("str_abort_post", T_FETCH,  32'hE5837054, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00);
      step("str_abort_post", T_DECODE, 32'hE5837054, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);

      @(negedge clk); #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
